// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two ALU requesters (A: execute, B: branch/address).
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 a_req_valid;
  logic                 a_req_ready;
  logic [31:0]          a_in1;
  logic [31:0]          a_in2;
  logic [3:0]           a_control;
  logic [TAG_WIDTH-1:0] a_tag;
  logic                 a_resp_valid;
  logic                 a_resp_ready;
  logic [31:0]          a_resp_out;
  logic [TAG_WIDTH-1:0] a_resp_tag;

  logic                 b_req_valid;
  logic                 b_req_ready;
  logic [31:0]          b_in1;
  logic [31:0]          b_in2;
  logic [3:0]           b_control;
  logic [TAG_WIDTH-1:0] b_tag;
  logic                 b_resp_valid;
  logic                 b_resp_ready;
  logic [31:0]          b_resp_out;
  logic [TAG_WIDTH-1:0] b_resp_tag;

  modport master (
    output a_req_valid, a_in1, a_in2, a_control, a_tag, a_resp_ready,
    output b_req_valid, b_in1, b_in2, b_control, b_tag, b_resp_ready,
    input  a_req_ready, a_resp_valid, a_resp_out, a_resp_tag,
    input  b_req_ready, b_resp_valid, b_resp_out, b_resp_tag
  );

  modport slave (
    input  a_req_valid, a_in1, a_in2, a_control, a_tag, a_resp_ready,
    input  b_req_valid, b_in1, b_in2, b_control, b_tag, b_resp_ready,
    output a_req_ready, a_resp_valid, a_resp_out, a_resp_tag,
    output b_req_ready, b_resp_valid, b_resp_out, b_resp_tag
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between ports A and B; result registered, 1-cycle latency.
// A held result blocks all new acceptance until its owner drains it or flush discards it.
module alu (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  control,
  output logic [31:0] result,
  output logic        undefined
);
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_LT  = 4'd8;
  localparam logic [3:0] ALU_LTU = 4'd9;
  localparam logic [3:0] ALU_NOP = 4'd10;

  always_comb begin
    result    = '0;
    undefined = 1'b0;
    case (control)
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      ALU_XOR: result = in1 ^ in2;
      ALU_SLL: result = in1 << in2[4:0];
      ALU_SRL: result = in1 >> in2[4:0];
      ALU_SRA: result = $unsigned($signed(in1) >>> in2[4:0]);
      ALU_LT:  result = {31'd0, $signed(in1) < $signed(in2)};
      ALU_LTU: result = {31'd0, in1 < in2};
      ALU_NOP: result = '0;
      default: undefined = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int TAG_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_arbiter_if.slave bus,
  output logic         illegal_op
);
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic [31:0]          in1;
    logic [31:0]          in2;
    logic [3:0]           control;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  port_e                last;
  port_e                res_owner;
  logic                 res_valid;
  logic [31:0]          res_data;
  logic [TAG_WIDTH-1:0] res_tag;

  req_t        req_a;
  req_t        req_b;
  req_t        sel;
  logic        drain;
  logic        free;
  logic        grant_a;
  logic        grant_b;
  logic        accept_a;
  logic        accept_b;
  logic        accept;
  logic        hold_a;
  logic        hold_b;
  logic [31:0] alu_result;
  logic        alu_undefined;

  assign req_a = {bus.a_in1, bus.a_in2, bus.a_control, bus.a_tag};
  assign req_b = {bus.b_in1, bus.b_in2, bus.b_control, bus.b_tag};

  assign drain = res_valid & ((res_owner == PORT_A) ? bus.a_resp_ready : bus.b_resp_ready);
  // rst_n gates ready so nothing handshakes while reset is asserted.
  assign free  = rst_n & ~flush & (~res_valid | drain);

  assign grant_a  = bus.a_req_valid & (~bus.b_req_valid | (last == PORT_B));
  assign grant_b  = bus.b_req_valid & (~bus.a_req_valid | (last == PORT_A));
  assign accept_a = free & grant_a;
  assign accept_b = free & grant_b;
  assign accept   = accept_a | accept_b;
  assign sel      = accept_b ? req_b : req_a;

  alu u_alu (
    .in1       (sel.in1),
    .in2       (sel.in2),
    .control   (sel.control),
    .result    (alu_result),
    .undefined (alu_undefined)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_owner  <= PORT_A;
      res_data   <= '0;
      res_tag    <= '0;
      last       <= PORT_B;
      illegal_op <= 1'b0;
    end else begin
      if (accept) begin
        res_valid <= 1'b1;
        res_owner <= accept_b ? PORT_B : PORT_A;
        res_data  <= alu_result;
        res_tag   <= sel.tag;
        last      <= accept_b ? PORT_B : PORT_A;
      end else if (flush || drain) begin
        res_valid <= 1'b0;
      end
      if (accept && alu_undefined) begin
        illegal_op <= 1'b1;
      end
    end
  end

  assign hold_a = res_valid & (res_owner == PORT_A);
  assign hold_b = res_valid & (res_owner == PORT_B);

  assign bus.a_req_ready  = accept_a;
  assign bus.b_req_ready  = accept_b;
  assign bus.a_resp_valid = hold_a;
  assign bus.b_resp_valid = hold_b;
  assign bus.a_resp_out   = hold_a ? res_data : '0;
  assign bus.b_resp_out   = hold_b ? res_data : '0;
  assign bus.a_resp_tag   = hold_a ? res_tag : '0;
  assign bus.b_resp_tag   = hold_b ? res_tag : '0;
endmodule
